rv32i_execute_stage: RTL

//  Consumer end of the decode->execute interface (D_E_bus_t) in the 5-stage RV32I pipeline.

---
 rtl/rv32i_types_pkg.sv | 121 ++++++++++++
 rtl/rv32i_alu.sv | 31 +++
 rtl/rv32i_execute_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types: decode->execute and execute->memory buses, their
// control enumerations and the bubble constants loaded on reset, flush and stall.
package rv32i_types_pkg;

   localparam int DATA_WIDTH = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_NONE      = 4'd0,
      ALU_ADD       = 4'd1,
      ALU_SUB       = 4'd2,
      ALU_SLL       = 4'd3,
      ALU_SLT       = 4'd4,
      ALU_SLTU      = 4'd5,
      ALU_XOR       = 4'd6,
      ALU_SRL       = 4'd7,
      ALU_SRA       = 4'd8,
      ALU_OR        = 4'd9,
      ALU_AND       = 4'd10,
      ALU_OPERAND_A = 4'd11,
      ALU_OPERAND_B = 4'd12
   } alu_op_enum;

   typedef enum logic [2:0] {
      COND_NONE = 3'd0,
      COND_EQ   = 3'd1,
      COND_NE   = 3'd2,
      COND_LT   = 3'd3,
      COND_GE   = 3'd4,
      COND_LTU  = 3'd5,
      COND_GEU  = 3'd6
   } cond_code_enum;

   typedef enum logic [0:0] {
      MUX_ALU_OPERAND_A_RS1 = 1'b0,
      MUX_ALU_OPERAND_A_PC  = 1'b1
   } mux_ALU_operand_A_enum;

   typedef enum logic [0:0] {
      MUX_ALU_OPERAND_B_RS2       = 1'b0,
      MUX_ALU_OPERAND_B_IMMEDIATE = 1'b1
   } mux_ALU_operand_B_enum;

   typedef enum logic [1:0] {
      MUX_WB_NONE       = 2'd0,
      MUX_WB_ALU_RESULT = 2'd1,
      MUX_WB_MEM        = 2'd2,
      MUX_WB_PC_PLUS_4  = 2'd3
   } mux_writeback_enum;

   typedef enum logic [1:0] {
      FORWARD_A_NONE         = 2'd0,
      FORWARD_A_RS1_DATA_D   = 2'd1,
      FORWARD_A_ALU_RESULT_M = 2'd2,
      FORWARD_A_ALU_RESULT_W = 2'd3
   } mux_forward_A_enum;

   typedef enum logic [1:0] {
      FORWARD_B_NONE         = 2'd0,
      FORWARD_B_RS2_DATA_D   = 2'd1,
      FORWARD_B_ALU_RESULT_M = 2'd2,
      FORWARD_B_ALU_RESULT_W = 2'd3
   } mux_forward_B_enum;

   typedef struct packed {
      logic                   valid;
      logic [31:0]            instruction;
      logic [4:0]             rs1_addr;
      logic [4:0]             rs2_addr;
      logic [4:0]             rd_addr;
      logic [31:0]            rs1_data;
      logic [31:0]            rs2_data;
      logic [31:0]            immediate;
      alu_op_enum             ALU_op;
      cond_code_enum          cond_code;
      mux_ALU_operand_A_enum  mux_ALU_operand_A_select;
      mux_ALU_operand_B_enum  mux_ALU_operand_B_select;
      mux_writeback_enum      mux_writeback_select;
      logic                   reg_write;
      logic                   memory_transaction;
      logic                   mem_write;
      logic                   jump;
      logic                   i_jump;
      logic                   branch;
      logic [2:0]             width_type;
   } D_E_bus_t;

   typedef struct packed {
      logic [31:0]            ALU_result;
      logic [31:0]            write_data;
      logic [4:0]             rd_addr;
      logic                   reg_write;
      logic                   memory_transaction;
      logic                   mem_write;
      logic [2:0]             width_type;
      mux_writeback_enum      mux_writeback_select;
      logic [31:0]            PC_plus_4;
      logic [31:0]            instruction;
      logic                   valid;
   } E_M_bus_t;

   localparam D_E_bus_t D_E_BUBBLE = '{
      valid: 1'b0, instruction: NOP_INSTR,
      rs1_addr: 5'd0, rs2_addr: 5'd0, rd_addr: 5'd0,
      rs1_data: 32'h0, rs2_data: 32'h0, immediate: 32'h0,
      ALU_op: ALU_NONE, cond_code: COND_NONE,
      mux_ALU_operand_A_select: MUX_ALU_OPERAND_A_RS1,
      mux_ALU_operand_B_select: MUX_ALU_OPERAND_B_RS2,
      mux_writeback_select: MUX_WB_NONE,
      reg_write: 1'b0, memory_transaction: 1'b0, mem_write: 1'b0,
      jump: 1'b0, i_jump: 1'b0, branch: 1'b0, width_type: 3'd0
   };

   localparam E_M_bus_t E_M_BUBBLE = '{
      ALU_result: 32'h0, write_data: 32'h0, rd_addr: 5'd0,
      reg_write: 1'b0, memory_transaction: 1'b0, mem_write: 1'b0,
      width_type: 3'd0, mux_writeback_select: MUX_WB_NONE,
      PC_plus_4: 32'h0, instruction: NOP_INSTR, valid: 1'b0
   };

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU; results wrap modulo 2^32 and no flags are produced.
module rv32i_alu
   import rv32i_types_pkg::*;
(
   input  alu_op_enum              ALU_op,
   input  logic [DATA_WIDTH-1:0]   A,
   input  logic [DATA_WIDTH-1:0]   B,
   output logic [DATA_WIDTH-1:0]   result
);

   // Operation select; unused and undefined codes yield zero.
   always_comb begin
      result = 32'h0;
      case (ALU_op)
         ALU_ADD:       result = A + B;
         ALU_SUB:       result = A - B;
         ALU_SLL:       result = A << B[4:0];
         ALU_SLT:       result = {31'h0, ($signed(A) < $signed(B))};
         ALU_SLTU:      result = {31'h0, (A < B)};
         ALU_XOR:       result = A ^ B;
         ALU_SRL:       result = A >> B[4:0];
         ALU_SRA:       result = $unsigned($signed(A) >>> B[4:0]);
         ALU_OR:        result = A | B;
         ALU_AND:       result = A & B;
         ALU_OPERAND_A: result = A;
         ALU_OPERAND_B: result = B;
         default:       result = 32'h0;
      endcase
   end

endmodule

// File: rtl/rv32i_execute_stage.sv
// RV32I execute stage: D/E register, operand forwarding, ALU, branch condition,
// redirect target and the registered E/M bus toward the memory stage.
module rv32i_execute_stage
   import rv32i_types_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall_E,
   input  logic                    flush_E,
   input  logic                    stall_M,
   input  D_E_bus_t                d_e_bus_i,
   input  logic [DATA_WIDTH-1:0]   PC_D,
   input  logic [DATA_WIDTH-1:0]   PC_plus_4_D,
   input  mux_forward_A_enum       mux_forward_A_select,
   input  mux_forward_B_enum       mux_forward_B_select,
   input  logic [DATA_WIDTH-1:0]   ALU_result_M,
   input  logic [DATA_WIDTH-1:0]   result_W,
   output logic [4:0]              rs1_addr_E,
   output logic [4:0]              rs2_addr_E,
   output logic [4:0]              rd_addr_E,
   output logic                    reg_write_E,
   output logic                    mem_read_E,
   output logic                    PC_src_E,
   output logic [DATA_WIDTH-1:0]   PC_target_E,
   output E_M_bus_t                e_m_bus_o
);

   D_E_bus_t                de_r;
   logic [DATA_WIDTH-1:0]   pc_e_r;
   logic [DATA_WIDTH-1:0]   pc_plus_4_e_r;
   E_M_bus_t                em_r;

   logic [DATA_WIDTH-1:0]   fwd_rs1_s;
   logic [DATA_WIDTH-1:0]   fwd_rs2_s;
   logic [DATA_WIDTH-1:0]   operand_a_s;
   logic [DATA_WIDTH-1:0]   operand_b_s;
   logic [DATA_WIDTH-1:0]   alu_result_s;
   logic                    cond_true_s;
   logic                    pc_src_s;
   logic [DATA_WIDTH-1:0]   pc_target_s;
   E_M_bus_t                em_next_s;

   // D/E register: flush beats stall so a redirect always squashes the E slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_r          <= D_E_BUBBLE;
         pc_e_r        <= 32'h0;
         pc_plus_4_e_r <= 32'h0;
      end else if (flush_E) begin
         de_r          <= D_E_BUBBLE;
         pc_e_r        <= 32'h0;
         pc_plus_4_e_r <= 32'h0;
      end else if (stall_E) begin
         de_r          <= de_r;
         pc_e_r        <= pc_e_r;
         pc_plus_4_e_r <= pc_plus_4_e_r;
      end else begin
         de_r          <= d_e_bus_i;
         de_r.valid    <= 1'b1;
         pc_e_r        <= PC_D;
         pc_plus_4_e_r <= PC_plus_4_D;
      end
   end

   // rs1 forwarding mux.
   always_comb begin
      fwd_rs1_s = de_r.rs1_data;
      case (mux_forward_A_select)
         FORWARD_A_ALU_RESULT_M: fwd_rs1_s = ALU_result_M;
         FORWARD_A_ALU_RESULT_W: fwd_rs1_s = result_W;
         default:                fwd_rs1_s = de_r.rs1_data;
      endcase
   end

   // rs2 forwarding mux; the result doubles as store data.
   always_comb begin
      fwd_rs2_s = de_r.rs2_data;
      case (mux_forward_B_select)
         FORWARD_B_ALU_RESULT_M: fwd_rs2_s = ALU_result_M;
         FORWARD_B_ALU_RESULT_W: fwd_rs2_s = result_W;
         default:                fwd_rs2_s = de_r.rs2_data;
      endcase
   end

   assign operand_a_s = (de_r.mux_ALU_operand_A_select == MUX_ALU_OPERAND_A_PC)
                        ? pc_e_r : fwd_rs1_s;
   assign operand_b_s = (de_r.mux_ALU_operand_B_select == MUX_ALU_OPERAND_B_IMMEDIATE)
                        ? de_r.immediate : fwd_rs2_s;

   rv32i_alu u_alu (
      .ALU_op (de_r.ALU_op),
      .A      (operand_a_s),
      .B      (operand_b_s),
      .result (alu_result_s)
   );

   // Branch condition, always on the forwarded registers rather than ALU operands.
   always_comb begin
      cond_true_s = 1'b0;
      case (de_r.cond_code)
         COND_EQ:  cond_true_s = (fwd_rs1_s == fwd_rs2_s);
         COND_NE:  cond_true_s = (fwd_rs1_s != fwd_rs2_s);
         COND_LT:  cond_true_s = ($signed(fwd_rs1_s) <  $signed(fwd_rs2_s));
         COND_GE:  cond_true_s = ($signed(fwd_rs1_s) >= $signed(fwd_rs2_s));
         COND_LTU: cond_true_s = (fwd_rs1_s <  fwd_rs2_s);
         COND_GEU: cond_true_s = (fwd_rs1_s >= fwd_rs2_s);
         default:  cond_true_s = 1'b0;
      endcase
   end

   // Redirect request; the target defaults to PC+imm so it never floats.
   always_comb begin
      pc_src_s    = 1'b0;
      pc_target_s = pc_e_r + de_r.immediate;
      if (de_r.valid) begin
         if (de_r.jump) begin
            pc_src_s = 1'b1;
         end else if (de_r.i_jump) begin
            pc_src_s    = 1'b1;
            pc_target_s = (fwd_rs1_s + de_r.immediate) & 32'hFFFF_FFFE;
         end else if (de_r.branch && cond_true_s) begin
            pc_src_s = 1'b1;
         end else begin
            pc_src_s = 1'b0;
         end
      end else begin
         pc_src_s = 1'b0;
      end
   end

   // Assemble the E/M payload from the current E slot.
   always_comb begin
      em_next_s                      = E_M_BUBBLE;
      em_next_s.ALU_result           = alu_result_s;
      em_next_s.write_data           = fwd_rs2_s;
      em_next_s.rd_addr              = de_r.rd_addr;
      em_next_s.reg_write            = de_r.reg_write;
      em_next_s.memory_transaction   = de_r.memory_transaction;
      em_next_s.mem_write            = de_r.mem_write;
      em_next_s.width_type           = de_r.width_type;
      em_next_s.mux_writeback_select = de_r.mux_writeback_select;
      em_next_s.PC_plus_4            = pc_plus_4_e_r;
      em_next_s.instruction          = de_r.instruction;
      em_next_s.valid                = de_r.valid;
   end

   // E/M register: a stalled E stage must not leak a duplicate into memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         em_r <= E_M_BUBBLE;
      end else if (stall_M) begin
         em_r <= em_r;
      end else if (stall_E) begin
         em_r <= E_M_BUBBLE;
      end else begin
         em_r <= em_next_s;
      end
   end

   assign rs1_addr_E  = de_r.rs1_addr;
   assign rs2_addr_E  = de_r.rs2_addr;
   assign rd_addr_E   = de_r.rd_addr;
   assign reg_write_E = de_r.reg_write;
   assign mem_read_E  = de_r.memory_transaction & ~de_r.mem_write;
   assign PC_src_E    = pc_src_s;
   assign PC_target_E = pc_target_s;
   assign e_m_bus_o   = em_r;

endmodule
